serial_adder: RTL

Bit-serial ripple adder that computes `a + b + cin` for two WIDTH-bit operands, one bit per clock, LSB first. Each bit step uses two cascaded half-adder cells (XOR for sum, AND for carry) plus a carry flip-flop. The block sits directly downstream of the half-adder cell in the arithmetic datapath. It trades latency for area and presents a start/busy/done handshake to its controller.

---
 rtl/serial_adder.sv | 107 ++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: computes a + b + cin one bit per clock, LSB first, using two
// cascaded half-adder cells and a carry flip-flop behind a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, ps, ps_next;
  logic             carry, carry_next;
  logic [CW-1:0]    cnt;
  logic             p, g1, s, g2;
  logic             last, accept;

  // NOTE: every signal written in this block gets a default first, so no path
  // through the case statement can leave a value held and infer a latch.
  always_comb begin
    p          = sa[0] ^ sb[0];
    g1         = sa[0] & sb[0];
    s          = p ^ carry;
    g2         = p & carry;
    carry_next = g1 | g2;
    // Shift the new sum bit in at the MSB; the concatenation keeps WIDTH=1 legal.
    ps_next    = WIDTH'({s, ps} >> 1);
    last       = (cnt == CW'(WIDTH - 1));
    accept     = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Reset clears the whole datapath, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      ps    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      sa    <= a;
      sb    <= b;
      ps    <= '0;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      ps    <= ps_next;
      carry <= carry_next;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum  <= ps_next;
        cout <= carry_next;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
